// File: rtl/mips_mem_pkg.sv
// Shared constants and FSM state type for the instruction-side main memory
// and the fetch-stage cache that talks to it.
package mips_mem_pkg;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = 4;
    localparam int REFILL_LATENCY = 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_e;
endpackage

// File: rtl/instruction_main_memory_if.sv
// Refill request/response and word load bus between the cache side (master)
// and the instruction main memory (slave).
interface instruction_main_memory_if;
    import mips_mem_pkg::*;

    logic              req_valid;
    logic [31:0]       req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [LINE_W-1:0] resp_data;
    logic              busy;
    logic              load_en;
    logic [31:0]       load_addr;
    logic [WORD_W-1:0] load_data;

    modport master (
        output req_valid, req_addr, load_en, load_addr, load_data,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_addr, load_en, load_addr, load_data,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/mem_line_array.sv
// Line-wide storage built from one word bank per word slot; synchronous
// line read that returns the pre-write contents on a same-edge write.
module mem_line_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_LINES = 64,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [1:0]        wr_sel,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [LINE_W-1:0] rd_data
);
    logic [LINE_W-1:0] line_rd;
    logic [LINE_W-1:0] rd_data_q, rd_data_d;

    for (genvar w = 0; w < WORDS_PER_LINE; w++) begin : g_word
        logic [WORD_W-1:0] bank [DEPTH_LINES];

        // Banks are deliberately left out of reset so program contents survive it.
        always_ff @(posedge clk) begin
            if (we && wr_sel == 2'(w))
                bank[wr_idx] <= wr_data;
        end

        assign line_rd[w*WORD_W +: WORD_W] = bank[rd_idx];
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rst)
            rd_data_d = '0;
        else if (rd_en)
            rd_data_d = line_rd;
    end

    always_ff @(posedge clk) rd_data_q <= rd_data_d;

    assign rd_data = rd_data_q;
endmodule

// File: rtl/instruction_main_memory.sv
// Fixed-latency line refill responder: accepts one request in IDLE, counts
// LATENCY-1 edges, then presents the 128-bit line for a single cycle.
module instruction_main_memory
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_LINES = 64,
    parameter int LATENCY     = REFILL_LATENCY
) (
    input logic                       clk,
    input logic                       rst,
    instruction_main_memory_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              resp_valid_q, resp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              capture;
    logic [LINE_W-1:0] line_q;

    logic [IDX_W-1:0] req_idx, load_idx;
    assign req_idx  = bus.req_addr[IDX_W+1:2];
    assign load_idx = bus.load_addr[IDX_W+1:2];

    // Address bits above the index wrap away; the request word offset is irrelevant.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[31:IDX_W+2], bus.req_addr[1:0],
                                bus.load_addr[31:IDX_W+2]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        resp_valid_d = 1'b0;
        capture      = 1'b0;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                idx_d   = req_idx;
                cnt_d   = CNT_W'(1);
                state_d = WAIT;
            end
            WAIT: if (cnt_q == CNT_LAST) begin
                capture      = 1'b1;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d      = IDLE;
            cnt_d        = '0;
            resp_valid_d = 1'b0;
            capture      = 1'b0;
        end
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        idx_q        <= idx_d;
        resp_valid_q <= resp_valid_d;
        req_ready_q  <= req_ready_d;
        busy_q       <= busy_d;
    end

    mem_line_array #(.DEPTH_LINES(DEPTH_LINES)) u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.load_en),
        .wr_idx  (load_idx),
        .wr_sel  (bus.load_addr[1:0]),
        .wr_data (bus.load_data),
        .rd_en   (capture),
        .rd_idx  (idx_q),
        .rd_data (line_q)
    );

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = line_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_instruction_main_memory.sv
// Bench for instruction_main_memory: word-addressed array model, directed
// scenarios for each timing rule, then randomized refills with stray loads.
module tb_instruction_main_memory;
    import mips_mem_pkg::*;

    localparam int DEPTH = 64;
    localparam int LAT   = 8;
    localparam int BOUND = 3 * LAT + 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] ref_mem [DEPTH*4];

    instruction_main_memory_if bus ();

    instruction_main_memory #(.DEPTH_LINES(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int word_slot(input logic [31:0] a);
        return int'(((a / 4) % DEPTH) * 4 + (a % 4));
    endfunction

    function automatic logic [127:0] model_line(input logic [31:0] a);
        int base;
        base = int'((a / 4) % DEPTH) * 4;
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    // One clock edge; the model takes any load the DUT sees on this edge.
    task automatic step();
        @(posedge clk);
        if (bus.load_en === 1'b1) ref_mem[word_slot(bus.load_addr)] = bus.load_data;
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d;
        step();
        bus.load_en = 1'b0;
    endtask

    // Drives one request from IDLE; lat is the edge offset (from the accept edge)
    // after which resp_valid was seen, or -1 if it never came.
    task automatic issue(input logic [31:0] addr, input int load_at,
                         input logic [31:0] ld_addr, input logic [31:0] ld_data,
                         input bit rand_loads,
                         output logic [127:0] exp_line, output logic [127:0] got,
                         output int lat);
        exp_line = '0; got = 'x; lat = -1;
        for (int k = 0; k <= BOUND; k++) begin
            if (k == 0) begin bus.req_valid = 1'b1; bus.req_addr = addr; end
            if (rand_loads) begin
                bus.load_en = 1'($urandom); bus.load_addr = $urandom; bus.load_data = $urandom;
            end
            if (k == load_at) begin
                bus.load_en = 1'b1; bus.load_addr = ld_addr; bus.load_data = ld_data;
            end
            // A word is in the response only if written before the capture edge.
            if (k == LAT - 1) exp_line = model_line(addr);
            step();
            bus.req_valid = 1'b0;
            bus.load_en   = 1'b0;
            if (bus.resp_valid === 1'b1) begin got = bus.resp_data; lat = k; break; end
        end
    endtask

    task automatic preload();
        for (int i = 0; i < DEPTH * 4; i++) load_word(32'(i), $urandom);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [127:0] e, g;
        int lat;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.req_valid = 1'($urandom); bus.req_addr = $urandom;
            bus.load_en = 1'b1; bus.load_data = $urandom;
            bus.load_addr = (i == 1) ? 32'h20 : $urandom;
            if (i == 1) v = bus.load_data;
            step();
        end
        rst = 1'b0; bus.req_valid = 1'b0; bus.load_en = 1'b0;
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
        n_checks++; if (bus.resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data got %h exp 0", bus.resp_data); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
        issue(32'h20, -1, '0, '0, 1'b0, e, g, lat);
        step();
        n_checks++; if (g[31:0] !== v) begin n_fail++; $display("FAIL reset_load_kept got %h exp %h", g[31:0], v); end
    endtask

    task automatic test_basic();
        logic [127:0] e, g;
        int lat;
        load_word(32'h10, 32'h11111111);
        load_word(32'h11, 32'h22222222);
        load_word(32'h12, 32'h33333333);
        load_word(32'h13, 32'h44444444);
        issue(32'h12, -1, '0, '0, 1'b0, e, g, lat);
        n_checks++; if (lat !== LAT - 1) begin n_fail++; $display("FAIL basic_latency got %0d exp %0d", lat, LAT - 1); end
        n_checks++; if (g !== 128'h44444444_33333333_22222222_11111111) begin n_fail++; $display("FAIL basic_data got %h", g); end
        n_checks++; if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_resp_state ready %b busy %b exp 0 1", bus.req_ready, bus.busy); end
        step();
        n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got %b exp 0", bus.resp_valid); end
        n_checks++; if (bus.resp_data !== 128'h44444444_33333333_22222222_11111111) begin n_fail++; $display("FAIL basic_hold got %h", bus.resp_data); end
        n_checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle ready %b busy %b exp 1 0", bus.req_ready, bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] e;
        int m;
        e = model_line(32'h0);
        bus.req_valid = 1'b1; bus.req_addr = 32'h0;
        // With the request held, one accept every LAT+1 edges.
        for (int k = 0; k <= 2 * LAT + 1; k++) begin
            step();
            m = k % (LAT + 1);
            n_checks++; if (bus.req_ready !== (m == LAT)) begin n_fail++; $display("FAIL b2b_ready edge+%0d got %b exp %b", k, bus.req_ready, m == LAT); end
            n_checks++; if (bus.resp_valid !== (m == LAT - 1)) begin n_fail++; $display("FAIL b2b_resp edge+%0d got %b exp %b", k, bus.resp_valid, m == LAT - 1); end
            if (m == LAT - 1) begin
                n_checks++; if (bus.resp_data !== e) begin n_fail++; $display("FAIL b2b_data edge+%0d got %h exp %h", k, bus.resp_data, e); end
            end
        end
        bus.req_valid = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        logic [127:0] e, g;
        int lat;
        load_word(32'h100, 32'hDEADBEEF);
        issue(32'h000, -1, '0, '0, 1'b0, e, g, lat);
        step();
        n_checks++; if (g[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wrap_word0 got %h exp deadbeef", g[31:0]); end
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL wrap_line got %h exp %h", g, e); end
    endtask

    task automatic test_load_during_wait();
        logic [127:0] e, g;
        int lat;
        load_word(32'h14, 32'h0BADBEEF);
        issue(32'h14, 3, 32'h14, 32'hCAFEF00D, 1'b0, e, g, lat);
        step();
        n_checks++; if (g[31:0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wait_load_early got %h exp cafef00d", g[31:0]); end
        issue(32'h14, LAT - 2, 32'h15, 32'hA5A5A5A5, 1'b0, e, g, lat);
        step();
        n_checks++; if (g[63:32] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wait_load_last got %h exp a5a5a5a5", g[63:32]); end
        issue(32'h14, LAT - 1, 32'h14, 32'h12345678, 1'b0, e, g, lat);
        step();
        n_checks++; if (g[31:0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wait_load_capture got %h exp cafef00d", g[31:0]); end
        issue(32'h14, -1, '0, '0, 1'b0, e, g, lat);
        step();
        n_checks++; if (g[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL wait_load_landed got %h exp 12345678", g[31:0]); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] e, g;
        int lat;
        bus.req_valid = 1'b1; bus.req_addr = 32'h10;
        step();
        bus.req_valid = 1'b0;
        for (int k = 1; k < 4; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle ready %b busy %b exp 1 0", bus.req_ready, bus.busy); end
        n_checks++; if (bus.resp_data !== '0) begin n_fail++; $display("FAIL rstmid_data got %h exp 0", bus.resp_data); end
        for (int k = 5; k <= 20; k++) begin
            n_checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_quiet edge+%0d valid %b ready %b", k, bus.resp_valid, bus.req_ready); end
            step();
        end
        issue(32'h10, -1, '0, '0, 1'b0, e, g, lat);
        step();
        n_checks++; if (g !== 128'h44444444_33333333_22222222_11111111) begin n_fail++; $display("FAIL rstmid_contents got %h", g); end
    endtask

    task automatic test_random();
        logic [127:0] e, g;
        int lat;
        for (int t = 0; t < 24; t++) begin
            for (int gap = $urandom_range(0, 3); gap > 0; gap--) begin
                bus.load_en = 1'($urandom); bus.load_addr = $urandom; bus.load_data = $urandom;
                step();
                bus.load_en = 1'b0;
            end
            issue($urandom, -1, '0, '0, 1'b1, e, g, lat);
            n_checks++; if (lat !== LAT - 1) begin n_fail++; $display("FAIL rand_latency #%0d got %0d exp %0d", t, lat, LAT - 1); end
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL rand_data #%0d got %h exp %h", t, g, e); end
            step();
            n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rand_pulse #%0d got %b exp 0", t, bus.resp_valid); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_addr = '0;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        preload();
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_load_during_wait();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_main_memory.md
# instruction_main_memory

Backing-store responder for the fetch-stage instruction cache. Holds program words, accepts one line-refill request at a time, and returns the full 128-bit, 4-word line after a fixed, parameterised latency. Default latency is 8 cycles, matching the cache's miss counter. A word-wide load port lets the testbench or boot logic write program contents.

## Interface
- `DEPTH_LINES`, default 64: number of 128-bit lines. Must be a power of 2.
- `LATENCY`, default 8: cycles from request accept to response. Minimum 2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  refill request.
- `req_addr`  in  32  word address.
  - Bits [1:0] are the word offset and are ignored.
  - Bits [log2(DEPTH_LINES)+1:2] are the line index.
  - Upper bits are ignored, so the index wraps modulo `DEPTH_LINES`.
- `req_ready`  out  1  high only in IDLE.
- `resp_valid`  out  1  one-cycle pulse; `resp_data` is valid.
- `resp_data`  out  128  line data.
  - [31:0] = word 0, [63:32] = word 1, [95:64] = word 2, [127:96] = word 3.
- `busy`  out  1  high in WAIT or RESP.
- `load_en`  in  1  write one word into the array.
- `load_addr`  in  32  word address for the load; same decode as `req_addr`, with [1:0] selecting the word in the line.
- `load_data`  in  32  word to write.

## Operation
- FSM states:
  - IDLE: `req_ready`=1. A request is accepted on an edge where `req_valid` && `req_ready`. On accept: latch the line index, set the counter to 1, go to WAIT.
  - WAIT: the counter increments each cycle. When the counter equals `LATENCY`-1, on that edge:
    - register the array line into `resp_data`;
    - set `resp_valid`;
    - go to RESP.
  - RESP: `resp_valid`=1 for exactly this cycle. Next state is IDLE unconditionally.
- Requests arriving while not in IDLE are not accepted. The requester holds `req_valid` and `req_addr` until it sees `req_ready`. There is no queueing.
- `resp_data` holds its last value after `resp_valid` drops, until the next response overwrites it.
- Load port:
  - Writes occur on any edge with `load_en`=1, in any state, including during WAIT.
  - A load to the in-flight line is visible in the response only if it is written on or before the edge before the capture edge. A load on the capture edge itself is not visible; the old word is returned, giving read-before-write semantics.
- The counter is `$clog2(LATENCY+1)` bits wide and never wraps in normal operation.

## Timing
- Reset values: state IDLE, counter 0, `req_ready`=1 from the first cycle after reset, `resp_valid`=0, `resp_data`=0, `busy`=0.
- The array is not cleared by reset.
- Latency: if the request is accepted on edge T, `resp_valid` is high in the cycle following edge T+`LATENCY`-1. The cache therefore sees the data `LATENCY` cycles after its request cycle.
- Back-to-back throughput: the next accept can happen at the earliest on edge T+`LATENCY`+1, i.e. one line per `LATENCY`+1 cycles.
- `rst` mid-WAIT or in RESP: the in-flight request is dropped and no response is produced. Outputs take their reset values on the next cycle.
- `rst` and `req_valid` together: reset wins and the request is not accepted.
- `load_en` together with `rst`: the write still occurs, because the array is unaffected by reset.

## Structure
- Shared package `mips_mem_pkg`:
  - `WORD_W`=32, `LINE_W`=128, `WORDS_PER_LINE`=4;
  - default refill latency constant 8;
  - FSM state typedef {IDLE, WAIT, RESP}.
- The cache should reference the same latency constant.
- Sub-module `mem_line_array`: `DEPTH_LINES` x 128 storage with a 32-bit word write port (line index plus word select) and a 128-bit synchronous line read with read-before-write.
- The top level contains the FSM, counter and handshake.

## Test plan
- **Basic refill.** Load words 0x11111111, 0x22222222, 0x33333333, 0x44444444 to addresses 0x10–0x13. Request `req_addr`=0x12 at T.
  - Expect `resp_valid` only in the cycle after edge T+7.
  - Expect `resp_data`=0x44444444_33333333_22222222_11111111.
- **Busy rejection.** Hold `req_valid` with address 0x00 continuously from T.
  - Expect `req_ready`=0 during T+1..T+8.
  - Expect a second accept at T+9 and a second response after edge T+16.
- **Wrap-around.** With `DEPTH_LINES`=64, load 0xDEADBEEF at 0x100, then request 0x000.
  - Expect word 0 of the response = 0xDEADBEEF.
- **Load during WAIT.** Request line 5, then write 0xCAFEF00D to 0x14 at T+3.
  - Expect the new word in `resp_data`[31:0].
  - Repeat with the write on edge T+7: expect the old word.
- **Reset mid-operation.** Accept at T, assert `rst` at T+4.
  - Expect no `resp_valid` through T+20.
  - Expect `req_ready`=1 from T+5.
  - Expect array contents intact: a subsequent request returns the pre-reset data.
- **Reset values.** Assert `rst` for 2 cycles with random inputs.
  - Expect `resp_valid`=0, `resp_data`=0, `busy`=0, `req_ready`=1 in the following cycle.
